bus_ram_slave: RTL
==================

# bus_ram_slave

Word-organised on-chip RAM slave on the core's external bus, directly downstream of the CPU top's bus master port. It accepts one read or write transaction at a time and latches the request. After a programmable number of wait states it returns a single-cycle acknowledge with read data or an error flag. The core's instruction-fetch and data paths reach this RAM through that one port.

## Interface
Parameters:
- ADDR_WIDTH, 12: number of word-address bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to 4*2^ADDR_WIDTH.
- WAIT_STATES, 2: cycles inserted between request capture and acknowledge; legal range 0..15.
- INIT_FILE, "": hex image loaded at elaboration via $readmemh when non-empty.

Ports:
- i_clk, input, 1: single clock; everything is on the rising edge.
- i_rst, input, 1: asynchronous, active-low reset.
- i_req, input, 1: transaction request; sampled only in IDLE.
- i_wr_en, input, 1: 1 = write, 0 = read; latched with i_req.
- i_addr, input, 32: byte address; bits [1:0] are ignored.
- i_wr_data, input, 32: write data; latched with i_req.
- i_byte_en, input, 4: byte lane enables for writes; bit n covers bits [8n+7:8n]. Ignored for reads.
- o_ack, output, 1: one-cycle transaction-complete strobe.
- o_rd_data, output, 32: read data; valid while o_ack=1 for a read.
- o_err, output, 1: out-of-range address; valid while o_ack=1.

## Operation
- The FSM has three states: IDLE, WAIT and ACK. o_ack is 1 exactly when the state is ACK.
- IDLE, i_req=1:
  - Latch i_addr, i_wr_en, i_wr_data and i_byte_en.
  - Compute hit = (i_addr - BASE_ADDR) < 4*2^ADDR_WIDTH, using 32-bit unsigned subtraction so wrap-around counts as a miss.
  - If WAIT_STATES=0, go to ACK. Otherwise go to WAIT with cnt=WAIT_STATES.
- WAIT: if cnt==1, go to ACK; otherwise cnt decrements. Input changes during WAIT are ignored.
- Entering ACK:
  - Read hit: o_rd_data <= mem[word index].
  - Miss: o_rd_data <= 0 and o_err <= 1.
  - Write: o_rd_data holds its previous value.
- Leaving ACK (the edge that ends the ACK cycle):
  - A write hit updates only the bytes whose i_byte_en bit is set.
  - i_byte_en=0000 writes nothing but is still acknowledged.
  - A write miss changes nothing.
- ACK always goes to IDLE. If i_req is still high, it is captured as a new request on the following edge. There is one dead cycle between back-to-back transactions.
- o_rd_data and o_err hold their values until the next entry into ACK.
- Reset (i_rst=0 at any time):
  - State goes to IDLE; cnt=0, o_ack=0, o_rd_data=0, o_err=0.
  - Any in-flight write is aborted with no RAM update.
  - RAM contents are not cleared.

## Timing
- Request captured at edge k: o_ack is high for exactly the cycle following edge k+WAIT_STATES, so request-to-ack latency is WAIT_STATES+1 cycles.
- Throughput: one transaction per WAIT_STATES+2 cycles.
- o_ack, o_rd_data and o_err are registered outputs, with no combinational path from any input.
- Read-after-write: a read captured in the cycle after a write's ACK returns the new data.
- Release of i_rst is synchronised externally; the block takes no action on deassertion beyond resuming in IDLE.

## Test plan
- WAIT_STATES=2, BASE_ADDR=0:
  - Write 0xDEADBEEF to 0x10 with byte_en=1111 -> o_ack high 3 cycles after capture, o_err=0.
  - Then read 0x10 -> o_rd_data=0xDEADBEEF with o_ack.
- Partial write 0x000000AA to 0x10 with byte_en=0001 over 0xDEADBEEF, then read -> 0xDEADBEAA.
- Write with byte_en=0000 -> ack received, subsequent read unchanged.
- Read 0x4000 with ADDR_WIDTH=12 (out of range) -> o_ack with o_err=1, o_rd_data=0. A following in-range read -> o_err=0.
- i_req held high continuously with WAIT_STATES=0 -> o_ack pulses every 2nd cycle, never two consecutive cycles.
- Assert i_rst=0 during WAIT of a write to 0x20 -> o_ack never rises, outputs 0, and a later read of 0x20 returns the old value.

Source files
------------

// File: rtl/bus_ram_slave.sv
// Word-organised RAM slave for the core's external bus: one transaction at a time,
// programmable wait states, single-cycle acknowledge with read data or an error flag.
module bus_ram_slave #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_err
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e                  r_state, w_next_state;
  logic [3:0]              r_cnt, w_next_cnt;

  logic                    r_wr_en;
  logic [31:0]             r_wr_data;
  logic [3:0]              r_byte_en;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_hit;

  logic [31:0]             w_offset;
  logic                    w_hit;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_capture;
  logic                    w_mem_we;
  logic                    w_ent_wr;
  logic                    w_ent_hit;
  logic [ADDR_WIDTH-1:0]   w_ent_idx;

  logic [31:0]             r_mem [DEPTH];

  // Unsigned 32-bit subtraction: addresses below BASE_ADDR wrap to huge offsets and miss.
  assign w_offset  = i_addr - BASE_ADDR;
  assign w_hit     = {1'b0, w_offset} < MEM_BYTES;
  assign w_idx     = w_offset[ADDR_WIDTH+1:2];
  assign w_capture = (r_state == S_IDLE) && i_req;

  // With zero wait states ACK is entered on the capture edge, so the live request is used.
  assign w_ent_wr  = w_capture ? i_wr_en : r_wr_en;
  assign w_ent_hit = w_capture ? w_hit   : r_hit;
  assign w_ent_idx = w_capture ? w_idx   : r_idx;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (WAIT_STATES == 0) begin
            w_next_state = S_ACK;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next_state = S_ACK;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_ack    = (r_state == S_ACK);
    w_mem_we = (r_state == S_ACK) && r_wr_en && r_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= 32'd0;
      r_byte_en <= 4'd0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
    end else if (w_capture) begin
      r_wr_en   <= i_wr_en;
      r_wr_data <= i_wr_data;
      r_byte_en <= i_byte_en;
      r_idx     <= w_idx;
      r_hit     <= w_hit;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rd_data <= 32'd0;
      o_err     <= 1'b0;
    end else if (w_next_state == S_ACK) begin
      if (!w_ent_hit) begin
        o_rd_data <= 32'd0;
        o_err     <= 1'b1;
      end else begin
        o_err <= 1'b0;
        if (!w_ent_wr) o_rd_data <= r_mem[w_ent_idx];
      end
    end
  end

  // NOTE: the array has no reset; contents survive i_rst, and reset only gates the write strobe.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_byte_en[b]) r_mem[r_idx][8*b +: 8] <= r_wr_data[8*b +: 8];
      end
    end
  end

endmodule
